// File: rtl/uram_stream_reader.sv
// Burst reader for a single-port URAM with one-cycle registered read latency.
// Streams the requested words in order on a valid/ready interface through a 2-entry FIFO.
module uram_stream_reader #(
  parameter int unsigned ADDR_LEN = 9,
  parameter int unsigned DATA_LEN = 72
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] start_addr,
  input  logic [ADDR_LEN:0]   count,
  output logic                busy,
  output logic                done,
  output logic                mem_we,
  output logic [DATA_LEN-1:0] mem_din,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic [DATA_LEN-1:0] mem_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data
);

  localparam int unsigned CNT_W  = ADDR_LEN + 1;
  localparam int unsigned FILL_W = 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_n;
  logic [ADDR_LEN-1:0] cur_addr, cur_addr_n, mem_addr_n;
  logic [CNT_W-1:0]    remaining, remaining_n;
  logic                addr_new, addr_new_n;
  logic                dout_pend, dout_pend_n;
  logic [FILL_W-1:0]   fill, fill_n, fill_after_pop;
  logic [DATA_LEN-1:0] tail, tail_n, head_n;
  logic                out_valid_n, busy_n, done_n;
  logic                pop, cap, issue;

  assign mem_we  = 1'b0;
  assign mem_din = '0;

  // addr_new: mem_addr changed at the last edge, its word appears on mem_dout next cycle.
  // dout_pend: mem_dout holds an uncaptured word; it stays put while mem_addr is not advanced,
  // so it acts as a third credit and lets the loop sustain one word per cycle.
  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    mem_addr_n  = mem_addr;
    remaining_n = remaining;
    busy_n      = busy;
    done_n      = 1'b0;
    issue       = 1'b0;

    pop            = out_valid & out_ready;
    cap            = dout_pend & ((fill != FILL_W'(2)) | pop);
    fill_after_pop = fill - FILL_W'(pop);
    head_n         = pop ? tail : out_data;
    tail_n         = tail;
    if (cap) begin
      if (fill_after_pop == FILL_W'(0)) head_n = mem_dout;
      else                              tail_n = mem_dout;
    end
    fill_n      = fill_after_pop + FILL_W'(cap);
    dout_pend_n = addr_new | (dout_pend & ~cap);

    case (state)
      IDLE: begin
        if (start) begin
          if (count == CNT_W'(0)) begin
            done_n = 1'b1;
          end else begin
            issue       = 1'b1;
            state_n     = RUN;
            busy_n      = 1'b1;
            mem_addr_n  = start_addr;
            cur_addr_n  = start_addr + ADDR_LEN'(1);
            remaining_n = count - CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (remaining != CNT_W'(0) && (3'(fill_n) + 3'(dout_pend_n)) < 3'd3) begin
          issue       = 1'b1;
          mem_addr_n  = cur_addr;
          cur_addr_n  = cur_addr + ADDR_LEN'(1);
          remaining_n = remaining - CNT_W'(1);
        end else if (remaining == CNT_W'(0) && !dout_pend_n && fill_n == FILL_W'(0)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    addr_new_n  = issue;
    out_valid_n = (fill_n != FILL_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      mem_addr  <= '0;
      remaining <= '0;
      addr_new  <= 1'b0;
      dout_pend <= 1'b0;
      fill      <= '0;
      out_data  <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      mem_addr  <= mem_addr_n;
      remaining <= remaining_n;
      addr_new  <= addr_new_n;
      dout_pend <= dout_pend_n;
      fill      <= fill_n;
      out_data  <= head_n;
      tail      <= tail_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule
